ckbuf_clk_div: RTL and testbench

Programmable, glitch-free clock divider that generates the clock driven into the clock-buffer tile's ckbuf_in input. The block is the immediate upstream stage of that tile.
It divides the global clk by an even ratio set by a static configuration word. Start and stop requests come from the fabric and are synchronised internally.
Output is fully registered with 50% duty; start and stop happen only on full-period boundaries, so no runt pulses reach the clock network.

---
 rtl/ckbuf_div_pkg.sv | 14 +
 rtl/ckbuf_div_sync.sv | 31 +++
 rtl/ckbuf_clk_div.sv | 104 ++++++++++
 tb/tb_ckbuf_clk_div.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ckbuf_div_pkg.sv
// Shared types and constants for the ckbuf divider slice.
// Holds the divider FSM state encoding and the default sizing parameters.
package ckbuf_div_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEFAULT = 4;
   localparam int SYNC_STAGES_MIN   = 2;

endpackage

// File: rtl/ckbuf_div_sync.sv
// Flop-chain synchroniser bringing a fabric-side level into the clk domain.
// Synchronous active-high reset clears every stage so a restart always pays the full latency.
module ckbuf_div_sync
   import ckbuf_div_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_MIN
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ckbuf_clk_div.sv
// Glitch-free even-ratio clock divider feeding the clock-buffer tile's ckbuf_in.
// Starts and stops only on full-period boundaries so no runt pulse reaches the clock network.
module ckbuf_clk_div
   import ckbuf_div_pkg::*;
#(
   parameter int DIV_WIDTH   = DIV_WIDTH_DEFAULT,
   parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 div_en,
   input  logic [DIV_WIDTH-1:0] div_sel,
   output logic                 div_clk_out,
   output logic                 div_active
);

   logic                 en_sync;
   div_state_e           state_q;
   div_state_e           state_d;
   logic                 div_clk_q;
   logic                 div_clk_d;
   logic                 active_q;
   logic                 active_d;
   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;
   logic [DIV_WIDTH-1:0] h_lat_q;
   logic [DIV_WIDTH-1:0] h_lat_d;
   logic                 phase_end;

   ckbuf_div_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (div_en),
      .q     (en_sync)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         div_clk_q <= 1'b0;
         active_q  <= 1'b0;
         cnt_q     <= '0;
         h_lat_q   <= '0;
      end else begin
         state_q   <= state_d;
         div_clk_q <= div_clk_d;
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         h_lat_q   <= h_lat_d;
      end
   end

   // Half-period length is frozen in h_lat for a whole period; div_sel is only
   // looked at when a new high phase begins.
   always_comb begin
      state_d   = state_q;
      div_clk_d = div_clk_q;
      cnt_d     = cnt_q;
      h_lat_d   = h_lat_q;
      phase_end = (cnt_q == h_lat_q);

      unique case (state_q)
         IDLE: begin
            div_clk_d = 1'b0;
            cnt_d     = '0;
            if (en_sync) begin
               state_d   = RUN;
               div_clk_d = 1'b1;
               h_lat_d   = div_sel;
            end
         end
         RUN, STOPPING: begin
            state_d = en_sync ? RUN : STOPPING;
            if (phase_end) begin
               cnt_d = '0;
               if (div_clk_q) begin
                  div_clk_d = 1'b0;
               end else if ((state_q == STOPPING) && !en_sync) begin
                  // Stop only at the end of a complete low phase.
                  state_d = IDLE;
               end else begin
                  div_clk_d = 1'b1;
                  h_lat_d   = div_sel;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            div_clk_d = 1'b0;
            cnt_d     = '0;
         end
      endcase

      active_d = (state_d != IDLE);
   end

   assign div_clk_out = div_clk_q;
   assign div_active  = active_q;

endmodule

// File: tb/tb_ckbuf_clk_div.sv
// Self-checking bench for ckbuf_clk_div: directed waveform pins plus randomized run/stop/reset
// traffic compared every cycle against a period-based reference model.
module tb_ckbuf_clk_div;

   localparam int DIV_WIDTH   = 4;
   localparam int SYNC_STAGES = 2;
   localparam int MAX_EDGES   = 16384;

   logic                 clk;
   logic                 reset;
   logic                 div_en;
   logic [DIV_WIDTH-1:0] div_sel;
   logic                 div_clk_out;
   logic                 div_active;

   int checks = 0;
   int errors = 0;
   int cur    = 0;

   ckbuf_clk_div #(
      .DIV_WIDTH   (DIV_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .div_en      (div_en),
      .div_sel     (div_sel),
      .div_clk_out (div_clk_out),
      .div_active  (div_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the output is described per period. A period starts at
   // edge p_start with half-length p_h; the output is high for the first p_h
   // edges of the period. At the period end the divider stops only if the
   // synchronised enable was low at this edge and the one before.
   bit en_hist [0:MAX_EDGES-1];
   int edge_no  = 0;
   int last_rst = -1000;
   bit m_run    = 0;
   bit m_clk    = 0;
   bit m_act    = 0;
   int p_start  = 0;
   int p_h      = 1;
   bit es_now;
   bit es_prev;

   function automatic bit en_sync_at(input int k);
      if ((k - last_rst) <= SYNC_STAGES || k < SYNC_STAGES) return 1'b0;
      return en_hist[(k - SYNC_STAGES) % MAX_EDGES];
   endfunction

   always @(posedge clk) begin
      en_hist[edge_no % MAX_EDGES] = div_en;
      if (reset) begin
         last_rst = edge_no;
         m_run    = 0;
         m_clk    = 0;
         m_act    = 0;
      end else begin
         es_now  = en_sync_at(edge_no);
         es_prev = en_sync_at(edge_no - 1);
         if (!m_run) begin
            if (es_now) begin
               m_run   = 1;
               p_start = edge_no;
               p_h     = int'(div_sel) + 1;
            end
         end else if ((edge_no - p_start) == 2 * p_h) begin
            if (!es_now && !es_prev) begin
               m_run = 0;
            end else begin
               p_start = edge_no;
               p_h     = int'(div_sel) + 1;
            end
         end
         m_clk = m_run && ((edge_no - p_start) < p_h);
         m_act = m_run;
      end
      edge_no++;
   end

   always @(posedge clk) begin
      #1;
      checks++;
      if (div_clk_out !== m_clk || div_active !== m_act) begin
         errors++;
         $display("[TB] FAIL model_cmp edge %0d: got clk=%b act=%b, expected clk=%b act=%b",
                  edge_no - 1, div_clk_out, div_active, m_clk, m_act);
      end
   end

   task automatic applyStimulus(input logic rst, input logic en, input logic [DIV_WIDTH-1:0] sel);
      reset   = rst;
      div_en  = en;
      div_sel = sel;
   endtask

   task automatic checkOutput(input string name, input logic exp_clk, input logic exp_act);
      checks++;
      if (div_clk_out !== exp_clk || div_active !== exp_act) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got clk=%b act=%b, expected clk=%b act=%b",
                  name, cur, div_clk_out, div_active, exp_clk, exp_act);
      end
   endtask

   task automatic advanceTo(input int k);
      while (cur < k) begin
         @(posedge clk);
         #2;
         cur++;
      end
   endtask

   task automatic restartWith(input logic [DIV_WIDTH-1:0] sel);
      applyStimulus(1'b1, 1'b0, sel);
      @(posedge clk); #2;
      @(posedge clk); #2;
      applyStimulus(1'b0, 1'b1, sel);
      cur = 0;
   endtask

   initial begin
      logic [1:18] pat3;
      logic        r_rst;
      logic        r_en;
      logic [3:0]  r_sel;

      applyStimulus(1'b1, 1'b0, 4'd0);
      @(posedge clk); #2;
      checkOutput("reset_state", 1'b0, 1'b0);

      $display("[TB] clk/2 start latency");
      restartWith(4'd0);
      advanceTo(2); checkOutput("sel0_e2", 1'b0, 1'b0);
      advanceTo(3); checkOutput("sel0_e3", 1'b1, 1'b1);
      advanceTo(4); checkOutput("sel0_e4", 1'b0, 1'b1);
      advanceTo(5); checkOutput("sel0_e5", 1'b1, 1'b1);
      advanceTo(6); checkOutput("sel0_e6", 1'b0, 1'b1);

      $display("[TB] divide by 8 waveform");
      pat3 = 18'b00_1111_0000_1111_0000;
      restartWith(4'd3);
      for (int k = 1; k <= 18; k++) begin
         advanceTo(k);
         checkOutput("sel3_wave", pat3[k], (k >= 3) ? 1'b1 : 1'b0);
      end

      $display("[TB] stop mid high phase");
      restartWith(4'd2);
      advanceTo(9);
      applyStimulus(1'b0, 1'b0, 4'd2);
      advanceTo(11); checkOutput("stop_high_end", 1'b1, 1'b1);
      advanceTo(12); checkOutput("stop_low_start", 1'b0, 1'b1);
      advanceTo(14); checkOutput("stop_low_last", 1'b0, 1'b1);
      advanceTo(15); checkOutput("stop_idle", 1'b0, 1'b0);
      advanceTo(18); checkOutput("stop_stays_idle", 1'b0, 1'b0);

      $display("[TB] one-cycle enable glitch");
      restartWith(4'd1);
      advanceTo(5);
      applyStimulus(1'b0, 1'b0, 4'd1);
      advanceTo(6);
      applyStimulus(1'b0, 1'b1, 4'd1);
      advanceTo(8);  checkOutput("glitch_e8", 1'b1, 1'b1);
      advanceTo(9);  checkOutput("glitch_e9", 1'b0, 1'b1);
      advanceTo(10); checkOutput("glitch_e10", 1'b0, 1'b1);
      advanceTo(11); checkOutput("glitch_e11", 1'b1, 1'b1);
      advanceTo(13); checkOutput("glitch_e13", 1'b0, 1'b1);

      $display("[TB] divide select change mid period");
      restartWith(4'd1);
      advanceTo(3);  checkOutput("selchg_e3", 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 4'd5);
      advanceTo(4);  checkOutput("selchg_e4", 1'b1, 1'b1);
      advanceTo(5);  checkOutput("selchg_e5", 1'b0, 1'b1);
      advanceTo(6);  checkOutput("selchg_e6", 1'b0, 1'b1);
      advanceTo(7);  checkOutput("selchg_e7", 1'b1, 1'b1);
      advanceTo(12); checkOutput("selchg_e12", 1'b1, 1'b1);
      advanceTo(13); checkOutput("selchg_e13", 1'b0, 1'b1);
      advanceTo(18); checkOutput("selchg_e18", 1'b0, 1'b1);
      advanceTo(19); checkOutput("selchg_e19", 1'b1, 1'b1);

      $display("[TB] max ratio and reset mid low phase");
      restartWith(4'd15);
      advanceTo(18); checkOutput("sel15_high_last", 1'b1, 1'b1);
      advanceTo(19); checkOutput("sel15_low_first", 1'b0, 1'b1);
      advanceTo(28);
      applyStimulus(1'b1, 1'b1, 4'd15);
      advanceTo(29); checkOutput("rst_mid_low", 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'd15);
      advanceTo(31); checkOutput("rst_resync", 1'b0, 1'b0);
      advanceTo(32); checkOutput("rst_restart", 1'b1, 1'b1);

      $display("[TB] randomized traffic");
      r_rst = 1'b0;
      r_en  = 1'b1;
      r_sel = 4'd2;
      for (int i = 0; i < 4000; i++) begin
         r_rst = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 29) == 0) r_en = ~r_en;
         if ($urandom_range(0, 59) == 0) r_sel = 4'($urandom_range(0, 15));
         applyStimulus(r_rst, r_en, r_sel);
         @(posedge clk); #2;
      end

      applyStimulus(1'b0, 1'b0, 4'd0);
      @(posedge clk); #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
